// File: rtl/stage_if_queue.sv
// Fetch stage: next-PC selection, single-outstanding instruction-memory
// handshake and a DEPTH-entry queue of fetched {pc, instr} pairs.
module stage_if_queue #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             redirect,
   input  logic [1:0]       pc_select,
   input  logic [WIDTH-1:0] pc_b,
   input  logic [WIDTH-1:0] pc_r,
   input  logic [WIDTH-1:0] pc_j,
   input  logic             id_stall,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic             imem_valid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc4,
   output logic             instr_valid,
   output logic             stall_me
);

   localparam int               PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CW         = PW + 1;
   localparam logic [CW-1:0]    DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
   localparam logic [PW-1:0]    PTR_ONE    = PW'(1);
   localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] fpc_q, fpc_d;
   logic [WIDTH-1:0] req_pc_q, req_pc_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] q_pc_q    [DEPTH];
   logic [WIDTH-1:0] q_pc_d    [DEPTH];
   logic [WIDTH-1:0] q_instr_q [DEPTH];
   logic [WIDTH-1:0] q_instr_d [DEPTH];

   logic [WIDTH-1:0] head_pc;
   logic [WIDTH-1:0] tgt_raw;
   logic [WIDTH-1:0] target;
   logic             accepted;
   logic             push;
   logic             pop;

   // Head-of-queue outputs; everything reads as zero while the queue is empty.
   always_comb begin
      head_pc     = q_pc_q[rd_ptr_q];
      instr_valid = (count_q != '0);
      pc          = instr_valid ? head_pc : '0;
      pc4         = instr_valid ? head_pc + PC_STEP : '0;
      instr       = instr_valid ? q_instr_q[rd_ptr_q] : '0;
      stall_me    = ~instr_valid & reset_n;
      imem_req    = (state_q == S_REQ) && (count_q < DEPTH_C);
      imem_addr   = fpc_q;
      accepted    = imem_req & imem_ack;
   end

   // Redirect target selection, word-aligned.
   always_comb begin
      case (pc_select)
         2'b00:   tgt_raw = pc4;
         2'b01:   tgt_raw = pc_b;
         2'b10:   tgt_raw = pc_r;
         default: tgt_raw = pc_j;
      endcase
      target = tgt_raw & ALIGN_MASK;
   end

   // Fetch FSM next state, fetch PC and queue push/pop bookkeeping.
   always_comb begin
      state_d   = state_q;
      fpc_d     = fpc_q;
      req_pc_d  = req_pc_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      q_pc_d    = q_pc_q;
      q_instr_d = q_instr_q;
      push      = 1'b0;
      pop       = 1'b0;

      if (redirect) begin
         fpc_d    = target;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         case (state_q)
            S_REQ:   state_d = accepted ? S_DROP : S_REQ;
            S_WAIT:  state_d = imem_valid ? S_REQ : S_DROP;
            // A response arriving in the redirect cycle still retires the
            // stale request, otherwise DROP would wait forever.
            S_DROP:  state_d = imem_valid ? S_REQ : S_DROP;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (accepted) begin
                  state_d  = S_WAIT;
                  req_pc_d = fpc_q;
               end
            end
            S_WAIT: begin
               if (imem_valid) begin
                  push    = 1'b1;
                  fpc_d   = req_pc_q + PC_STEP;
                  state_d = S_REQ;
               end
            end
            default: begin
               if (imem_valid) state_d = S_REQ;
            end
         endcase

         pop = instr_valid & ~id_stall;

         if (push) begin
            q_pc_d[wr_ptr_q]    = req_pc_q;
            q_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_d = count_q + CNT_ONE;
         else if (pop && !push) count_d = count_q - CNT_ONE;
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         fpc_q    <= RESET_PC;
         req_pc_q <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         req_pc_q <= req_pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage; contents are only observed through count_q.
   always_ff @(posedge clock) begin
      q_pc_q    <= q_pc_d;
      q_instr_q <= q_instr_d;
   end

endmodule
